multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/opcode_class.sv | 31 +++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Datapath-facing select encodings live here so the decoder, the FSM and the bench all use the same values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC,
    MEMADR,
    MEMRD,
    MEMWR,
    WB,
    BRANCH,
    JUMP,
    TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_OPIMM,
    CLS_LUI,
    CLS_AUIPC,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_FUNCT  = 2'd1,
    ALU_PASS_B = 2'd2
  } alu_op_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode decoder: maps instr[6:0] to an instruction class,
// the immediate format for the extender, and a legality flag.
module opcode_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] op_class,
  output logic [2:0] imm_type,
  output logic       legal
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    op_class = CLS_ILLEGAL;
    imm_type = IMM_I;
    legal    = 1'b1;
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_IMM:    op_class = CLS_OPIMM;
      OP_LUI:    begin op_class = CLS_LUI;    imm_type = IMM_U; end
      OP_AUIPC:  begin op_class = CLS_AUIPC;  imm_type = IMM_U; end
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  begin op_class = CLS_STORE;  imm_type = IMM_S; end
      OP_BRANCH: begin op_class = CLS_BRANCH; imm_type = IMM_B; end
      OP_JAL:    begin op_class = CLS_JAL;    imm_type = IMM_J; end
      OP_JALR:   op_class = CLS_JALR;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and writeback
// and drives the datapath strobes and selects. Also keeps a sticky illegal flag and a retire counter.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  imm_type,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      state, state_next;
  op_class_t   op_cls;
  logic [3:0]  cls_bits;
  logic        legal;
  logic        started;
  logic        retire;
  logic        illegal_q;
  logic [31:0] retired_q;
  logic        unused_instr;

  opcode_class u_opcode_class (
    .opcode   (instr[6:0]),
    .op_class (cls_bits),
    .imm_type (imm_type),
    .legal    (legal)
  );

  assign op_cls       = op_class_t'(cls_bits);
  assign unused_instr = ^instr[31:7];

  // Outputs are held at 0 while reset is high, not just after the edge that samples it.
  assign illegal = illegal_q & ~reset;
  assign retired = reset ? 32'd0 : retired_q;

  // started stays low for one cycle after reset release, so the first fetch request
  // appears in the second cycle and any stray ack in the idle cycle is ignored.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = PC_PLUS4;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;

    if (!reset && started) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            pc_sel     = PC_PLUS4;
            state_next = DECODE;
          end
        end

        DECODE: begin
          if (!legal) begin
            state_next = TRAP;
          end else begin
            case (op_cls)
              CLS_R, CLS_OPIMM, CLS_LUI, CLS_AUIPC: state_next = EXEC;
              CLS_LOAD, CLS_STORE:                  state_next = MEMADR;
              CLS_BRANCH:                           state_next = BRANCH;
              CLS_JAL, CLS_JALR:                    state_next = JUMP;
              default:                              state_next = TRAP;
            endcase
          end
        end

        EXEC: begin
          case (op_cls)
            CLS_R:     alu_op = ALU_FUNCT;
            CLS_OPIMM: begin alu_src_b = 1'b1; alu_op = ALU_FUNCT;  end
            CLS_LUI:   begin alu_src_b = 1'b1; alu_op = ALU_PASS_B; end
            CLS_AUIPC: begin alu_src_a = 1'b1; alu_src_b = 1'b1; alu_op = ALU_ADD; end
            default:   alu_op = ALU_ADD;
          endcase
          state_next = WB;
        end

        MEMADR: begin
          alu_src_b  = 1'b1;
          alu_op     = ALU_ADD;
          state_next = (op_cls == CLS_STORE) ? MEMWR : MEMRD;
        end

        MEMRD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ack) state_next = WB;
        end

        MEMWR: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = 1'b1;
          if (mem_ack) begin
            retire     = 1'b1;
            state_next = FETCH;
          end
        end

        WB: begin
          reg_write  = 1'b1;
          wb_sel     = (op_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
          retire     = 1'b1;
          state_next = FETCH;
        end

        BRANCH: begin
          pc_write   = br_taken;
          pc_sel     = PC_IMM;
          retire     = 1'b1;
          state_next = FETCH;
        end

        JUMP: begin
          reg_write = 1'b1;
          wb_sel    = WB_PC4;
          pc_write  = 1'b1;
          if (op_cls == CLS_JALR) begin
            pc_sel    = PC_ALU;
            alu_src_b = 1'b1;
            alu_op    = ALU_ADD;
          end else begin
            pc_sel = PC_IMM;
          end
          retire     = 1'b1;
          state_next = FETCH;
        end

        TRAP:    state_next = TRAP;
        default: state_next = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      started   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
      if (state_next == TRAP) illegal_q <= 1'b1;
      if (retire)             retired_q <= retired_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: instruction sequences with hand-derived
// per-cycle control outputs, reset behaviour, trap stickiness and retire-counter wrap.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0000_0013;
  logic        mem_ack = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
  logic        alu_src_a, alu_src_b, illegal;
  logic [1:0]  pc_sel, wb_sel, alu_op;
  logic [2:0]  imm_type;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_LB    = 32'h0283_0283;
  localparam logic [31:0] I_BLT   = 32'hfe92_46e3;
  localparam logic [31:0] I_SH    = 32'h0012_9023;
  localparam logic [31:0] I_JAL   = 32'hffdf_f0ef;
  localparam logic [31:0] I_JALR  = 32'h0000_80e7;
  localparam logic [31:0] I_AUIPC = 32'h0000_1117;
  localparam logic [31:0] I_ADD   = 32'h0020_81b3;
  localparam logic [31:0] I_LUI   = 32'h1234_50b7;
  localparam logic [31:0] I_BAD   = 32'h0000_007F;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } outs_t;

  outs_t e, o;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ack   (mem_ack),
    .br_taken  (br_taken),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .imm_type  (imm_type),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  function automatic outs_t snap();
    outs_t s;
    s.mem_req   = mem_req;
    s.mem_we    = mem_we;
    s.addr_sel  = addr_sel;
    s.ir_write  = ir_write;
    s.pc_write  = pc_write;
    s.pc_sel    = pc_sel;
    s.reg_write = reg_write;
    s.wb_sel    = wb_sel;
    s.alu_src_a = alu_src_a;
    s.alu_src_b = alu_src_b;
    s.alu_op    = alu_op;
    s.illegal   = illegal;
    return s;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic cyc(input logic ack, input logic bt);
    @(negedge clk);
    mem_ack  = ack;
    br_taken = bt;
    #1;
  endtask

  // Two reset edges, then release; on return the bench sits in the idle cycle after release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1; instr = I_LB;
    #1;
    e = '0; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_outs: got %h want %h", o, e); end
    checks++;
    if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired: got %h want 0", retired); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b0;
    #1;
    e = '0; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_idle_cycle: got %h want %h", o, e); end
    checks++;
    if (dut.state !== FETCH) begin failures++; $display("FAIL reset_state: got %0d want %0d", dut.state, FETCH); end
    cyc(1'b0, 1'b0);
    e = '0; e.mem_req = 1'b1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_req_rises: got %h want %h", o, e); end
  endtask

  task automatic test_load();
    instr = I_LB;
    do_reset();
    cyc(1'b1, 1'b0);
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; o = snap(); checks++;
    if (o !== e || dut.state !== FETCH) begin failures++; $display("FAIL lb_fetch: got %h st %0d want %h", o, dut.state, e); end
    cyc(1'b0, 1'b0);
    e = '0; o = snap(); checks++;
    if (o !== e || dut.state !== DECODE) begin failures++; $display("FAIL lb_decode: got %h st %0d want %h", o, dut.state, e); end
    checks++;
    if (imm_type !== 3'd0) begin failures++; $display("FAIL lb_imm_type: got %0d want 0", imm_type); end
    cyc(1'b0, 1'b0);
    e = '0; e.alu_src_b = 1'b1; o = snap(); checks++;
    if (o !== e || dut.state !== MEMADR) begin failures++; $display("FAIL lb_memadr: got %h st %0d want %h", o, dut.state, e); end
    cyc(1'b1, 1'b0);
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; o = snap(); checks++;
    if (o !== e || dut.state !== MEMRD) begin failures++; $display("FAIL lb_memrd: got %h st %0d want %h", o, dut.state, e); end
    cyc(1'b0, 1'b0);
    e = '0; e.reg_write = 1'b1; e.wb_sel = 2'd1; o = snap(); checks++;
    if (o !== e || dut.state !== WB) begin failures++; $display("FAIL lb_wb: got %h st %0d want %h", o, dut.state, e); end
    cyc(1'b0, 1'b0);
    checks++;
    if (retired !== 32'd1 || dut.state !== FETCH) begin failures++; $display("FAIL lb_retired: got %h st %0d want 1", retired, dut.state); end
  endtask

  task automatic test_branch();
    instr = I_BLT;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      checks++;
      if (imm_type !== 3'd2) begin failures++; $display("FAIL blt_imm_type: got %0d want 2", imm_type); end
      cyc(1'b0, (pass == 0));
      e = '0; e.pc_write = (pass == 0); e.pc_sel = 2'd1; o = snap(); checks++;
      if (o !== e) begin failures++; $display("FAIL blt_branch pass%0d: got %h want %h", pass, o, e); end
    end
    cyc(1'b0, 1'b0);
    e = '0; e.mem_req = 1'b1; o = snap(); checks++;
    if (o !== e || retired !== 32'd2) begin failures++; $display("FAIL blt_back_to_fetch: got %h ret %h want %h ret 2", o, retired, e); end
  endtask

  task automatic test_store();
    instr = I_SH;
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (imm_type !== 3'd1) begin failures++; $display("FAIL sh_imm_type: got %0d want 1", imm_type); end
    cyc(1'b0, 1'b0);
    e = '0; e.alu_src_b = 1'b1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL sh_memadr: got %h want %h", o, e); end
    for (int i = 0; i < 4; i++) begin
      cyc((i == 3), 1'b0);
      e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1; o = snap(); checks++;
      if (o !== e) begin failures++; $display("FAIL sh_memwr cycle%0d: got %h want %h", i, o, e); end
    end
    cyc(1'b0, 1'b0);
    e = '0; e.mem_req = 1'b1; o = snap(); checks++;
    if (o !== e || retired !== 32'd1) begin failures++; $display("FAIL sh_done: got %h ret %h want %h ret 1", o, retired, e); end
  endtask

  task automatic test_jump_alu();
    instr = I_JAL;
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (imm_type !== 3'd4) begin failures++; $display("FAIL jal_imm_type: got %0d want 4", imm_type); end
    cyc(1'b0, 1'b0);
    e = '0; e.reg_write = 1'b1; e.wb_sel = 2'd2; e.pc_write = 1'b1; e.pc_sel = 2'd1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL jal_jump: got %h want %h", o, e); end
    cyc(1'b1, 1'b0); instr = I_JALR;
    cyc(1'b0, 1'b0);
    checks++;
    if (imm_type !== 3'd0) begin failures++; $display("FAIL jalr_imm_type: got %0d want 0", imm_type); end
    cyc(1'b0, 1'b0);
    e = '0; e.reg_write = 1'b1; e.wb_sel = 2'd2; e.pc_write = 1'b1; e.pc_sel = 2'd2; e.alu_src_b = 1'b1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL jalr_jump: got %h want %h", o, e); end
    cyc(1'b1, 1'b0); instr = I_AUIPC;
    cyc(1'b0, 1'b0);
    checks++;
    if (imm_type !== 3'd3) begin failures++; $display("FAIL auipc_imm_type: got %0d want 3", imm_type); end
    cyc(1'b0, 1'b0);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 1'b1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL auipc_exec: got %h want %h", o, e); end
    cyc(1'b0, 1'b0);
    e = '0; e.reg_write = 1'b1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL auipc_wb: got %h want %h", o, e); end
    cyc(1'b1, 1'b0); instr = I_ADD;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    e = '0; e.alu_op = 2'd1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL add_exec: got %h want %h", o, e); end
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); instr = I_LUI;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    e = '0; e.alu_src_b = 1'b1; e.alu_op = 2'd2; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL lui_exec: got %h want %h", o, e); end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (retired !== 32'd5) begin failures++; $display("FAIL jump_alu_retired: got %0d want 5", retired); end
  endtask

  task automatic test_trap();
    instr = I_BAD;
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    e = '0; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL trap_decode: got %h want %h", o, e); end
    for (int i = 0; i < 20; i++) begin
      cyc(i[0], 1'b0);
      e = '0; e.illegal = 1'b1; o = snap(); checks++;
      if (o !== e || dut.state !== TRAP) begin failures++; $display("FAIL trap_sticky cycle%0d: got %h st %0d want %h", i, o, dut.state, e); end
    end
    checks++;
    if (retired !== 32'd0) begin failures++; $display("FAIL trap_retired: got %0d want 0", retired); end
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL trap_reset_illegal: got %b want 0", illegal); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    e = '0; o = snap(); checks++;
    if (o !== e || dut.state !== FETCH) begin failures++; $display("FAIL trap_after_reset: got %h st %0d want %h", o, dut.state, e); end
  endtask

  task automatic test_reset_midtxn();
    instr = I_ADD;
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); instr = I_LB;
    checks++;
    if (retired !== 32'd1) begin failures++; $display("FAIL mid_pre_retired: got %0d want 1", retired); end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (dut.state !== MEMRD || mem_req !== 1'b1) begin failures++; $display("FAIL mid_in_memrd: got st %0d req %b want st %0d req 1", dut.state, mem_req, MEMRD); end
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1;
    #1;
    e = '0; o = snap(); checks++;
    if (o !== e || retired !== 32'd0) begin failures++; $display("FAIL mid_during_reset: got %h ret %h want %h ret 0", o, retired, e); end
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b0;
    #1;
    e = '0; o = snap(); checks++;
    if (o !== e || retired !== 32'd0 || dut.state !== FETCH) begin failures++; $display("FAIL mid_after_reset: got %h ret %h st %0d want %h", o, retired, dut.state, e); end
    cyc(1'b1, 1'b0);
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; o = snap(); checks++;
    if (o !== e) begin failures++; $display("FAIL mid_refetch: got %h want %h", o, e); end
    dut.retired_q = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (retired !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload: got %h want ffffffff", retired); end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (retired !== 32'hFFFF_FFFF || reg_write !== 1'b1) begin failures++; $display("FAIL wrap_in_wb: got ret %h rw %b want ffffffff 1", retired, reg_write); end
    cyc(1'b0, 1'b0);
    checks++;
    if (retired !== 32'd0) begin failures++; $display("FAIL wrap_to_zero: got %h want 0", retired); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_branch();
    test_store();
    test_jump_alu();
    test_trap();
    test_reset_midtxn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
